layer7_fc_sequencer: RTL and testbench

Top-level controller for the layer-7 fully-connected stage. It waits for layer 6 to finish writing the pixel buffer and loads the FC bias chain once after reset. It then launches the FC pass, watches it with a watchdog, and captures the ten 16-bit logits. A sequential argmax runs over the captured logits, and the winning class is returned over a valid/ready handshake.

---
 rtl/layer7_pkg.sv | 18 +
 rtl/layer7_argmax.sv | 49 ++++
 rtl/layer7_fc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_layer7_fc_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/layer7_pkg.sv
// Shared types and constants for the layer-7 fully-connected sequencer.
package layer7_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_BIAS_LOAD = 3'd1,
    S_BIAS_WAIT = 3'd2,
    S_START     = 3'd3,
    S_CALC      = 3'd4,
    S_ARGMAX    = 3'd5,
    S_OUT       = 3'd6
  } l7_seq_state_t;

  localparam int L7_CHANNELS         = 10;
  localparam int L7_BIAS_LOAD_CYCLES = L7_CHANNELS + 1;
  localparam int L7_CLASS_W          = 4;

endpackage

// File: rtl/layer7_argmax.sv
// Sequential argmax over the captured logits: one signed compare per cycle.
// On start, channel 0 seeds the running maximum; channels 1..CHANNELS-1
// follow, and only a strictly greater logit replaces it (ties keep the
// lower index). done is high during the cycle that evaluates the last channel.
import layer7_pkg::*;

module layer7_argmax #(
  parameter int CHANNELS = L7_CHANNELS,
  parameter int WORD     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CHANNELS*WORD-1:0]     logits,
  output logic                         done,
  output logic [L7_CLASS_W-1:0]        max_class,
  output logic signed [WORD-1:0]       max_score
);

  logic                    active;
  logic [L7_CLASS_W-1:0]   idx;
  logic signed [WORD-1:0]  cand;

  assign cand = logits[idx*WORD +: WORD];
  assign done = active && (idx == L7_CLASS_W'(CHANNELS - 1));

  // Walk the index counter and keep the running maximum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active    <= 1'b0;
      idx       <= '0;
      max_class <= '0;
      max_score <= '0;
    end else if (start) begin
      active    <= 1'b1;
      idx       <= L7_CLASS_W'(1);
      max_class <= '0;
      max_score <= logits[WORD-1:0];
    end else if (active) begin
      if (cand > max_score) begin
        max_class <= idx;
        max_score <= cand;
      end
      if (done) active <= 1'b0;
      else      idx    <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/layer7_fc_sequencer.sv
// Layer-7 FC controller: bias load once after reset, FC launch with a
// watchdog, logit capture, argmax and a valid/ready result handshake.
//
//   state       | meaning
//   ------------+----------------------------------------------------
//   IDLE        | waiting for layer6_done (or pending) with weights valid
//   BIAS_LOAD   | bias_store_done pulse, starts bias shift-in
//   BIAS_WAIT   | CHANNELS+1 cycles for the bias chain to fill
//   START       | pixel_store_done pulse, watchdog armed
//   CALC        | waiting for fc_calculation_done, watchdog counting
//   ARGMAX      | sequential argmax over the captured logits
//   OUT         | result_valid held until result_ready
import layer7_pkg::*;

module layer7_fc_sequencer #(
  parameter int CHANNELS     = L7_CHANNELS,
  parameter int WORD         = 16,
  parameter int CALC_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      layer6_done,
  input  logic                      weight_loaded,
  input  logic                      fc_calculation_done,
  input  logic [CHANNELS*WORD-1:0]  fc_output_data,
  output logic                      bias_store_done,
  output logic                      pixel_store_done,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [L7_CLASS_W-1:0]     result_class,
  output logic [WORD-1:0]           result_score,
  output logic [CHANNELS*WORD-1:0]  result_logits,
  output logic                      busy,
  output logic                      err_timeout,
  output logic                      err_overrun,
  input  logic                      clear_err
);

  localparam int BC_W = $clog2(CHANNELS + 1);
  localparam int WD_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;

  l7_seq_state_t            state;
  logic                     pending;
  logic                     bias_programmed;
  logic [BC_W-1:0]          bias_cnt;
  logic [WD_W-1:0]          wdog;
  logic                     argmax_start;
  logic                     argmax_done;
  logic [CHANNELS*WORD-1:0] argmax_logits;
  logic signed [WORD-1:0]   argmax_score;

  // Channel 0 seeds the maximum in the capture cycle, before result_logits updates.
  assign argmax_start  = (state == S_CALC) && fc_calculation_done;
  assign argmax_logits = (state == S_CALC) ? fc_output_data : result_logits;
  assign busy          = (state != S_IDLE);
  assign result_score  = argmax_score;

  layer7_argmax #(
    .CHANNELS (CHANNELS),
    .WORD     (WORD)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .start     (argmax_start),
    .logits    (argmax_logits),
    .done      (argmax_done),
    .max_class (result_class),
    .max_score (argmax_score)
  );

  // Sequencer FSM with registered strobes, counters and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_IDLE;
      pending          <= 1'b0;
      bias_programmed  <= 1'b0;
      bias_cnt         <= '0;
      wdog             <= '0;
      bias_store_done  <= 1'b0;
      pixel_store_done <= 1'b0;
      result_valid     <= 1'b0;
      result_logits    <= '0;
      err_timeout      <= 1'b0;
      err_overrun      <= 1'b0;
    end else begin
      bias_store_done  <= 1'b0;
      pixel_store_done <= 1'b0;

      // Clear first so a same-cycle error set below takes priority.
      if (clear_err) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end

      if ((state != S_IDLE) && layer6_done) begin
        if (pending) err_overrun <= 1'b1;
        else         pending     <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if ((layer6_done || pending) && weight_loaded) begin
            pending <= 1'b0;
            if (bias_programmed) begin
              state            <= S_START;
              pixel_store_done <= 1'b1;
            end else begin
              state           <= S_BIAS_LOAD;
              bias_store_done <= 1'b1;
            end
          end else if (layer6_done) begin
            pending <= 1'b1;
          end
        end
        S_BIAS_LOAD: begin
          state    <= S_BIAS_WAIT;
          bias_cnt <= BC_W'(CHANNELS);
        end
        S_BIAS_WAIT: begin
          if (bias_cnt == '0) begin
            bias_programmed  <= 1'b1;
            state            <= S_START;
            pixel_store_done <= 1'b1;
          end else begin
            bias_cnt <= bias_cnt - 1'b1;
          end
        end
        S_START: begin
          wdog  <= WD_W'(CALC_TIMEOUT - 1);
          state <= S_CALC;
        end
        S_CALC: begin
          if (fc_calculation_done) begin
            result_logits <= fc_output_data;
            state         <= S_ARGMAX;
          end else if (wdog == '0) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            wdog <= wdog - 1'b1;
          end
        end
        S_ARGMAX: begin
          if (argmax_done) begin
            result_valid <= 1'b1;
            state        <= S_OUT;
          end
        end
        S_OUT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer7_fc_sequencer.sv
// Directed bench for the layer-7 FC sequencer with hand-computed expectations.
module tb_layer7_fc_sequencer;
  import layer7_pkg::*;

  localparam int CH = 10;
  localparam int W  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            layer6_done;
  logic            weight_loaded;
  logic            fc_calculation_done;
  logic [CH*W-1:0] fc_output_data;
  logic            bias_store_done;
  logic            pixel_store_done;
  logic            result_valid;
  logic            result_ready;
  logic [3:0]      result_class;
  logic [W-1:0]    result_score;
  logic [CH*W-1:0] result_logits;
  logic            busy;
  logic            err_timeout;
  logic            err_overrun;
  logic            clear_err;

  int errors = 0;
  int checks = 0;
  logic flag;

  int v1 [10] = '{5, -3, 9, 9, 0, 0, 0, 0, 0, 0};
  int v2 [10] = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
  int v3 [10] = '{-10, -20, -30, -40, -50, -60, -70, 100, -5, -1};

  layer7_fc_sequencer #(.CHANNELS(CH), .WORD(W), .CALC_TIMEOUT(1024)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .layer6_done         (layer6_done),
    .weight_loaded       (weight_loaded),
    .fc_calculation_done (fc_calculation_done),
    .fc_output_data      (fc_output_data),
    .bias_store_done     (bias_store_done),
    .pixel_store_done    (pixel_store_done),
    .result_valid        (result_valid),
    .result_ready        (result_ready),
    .result_class        (result_class),
    .result_score        (result_score),
    .result_logits       (result_logits),
    .busy                (busy),
    .err_timeout         (err_timeout),
    .err_overrun         (err_overrun),
    .clear_err           (clear_err)
  );

  always #5 clk = ~clk;

  function automatic logic [CH*W-1:0] pack10(input int v [10]);
    logic [CH*W-1:0] r;
    logic [31:0]     t;
    r = '0;
    for (int i = 0; i < CH; i++) begin
      t = v[i];
      r[i*W +: W] = t[W-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    layer6_done = 1'b0;
    weight_loaded = 1'b0;
    fc_calculation_done = 1'b0;
    fc_output_data = '0;
    result_ready = 1'b0;
    clear_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_bias",   192'(bias_store_done), 192'(0));
    check("rst_pixel",  192'(pixel_store_done), 192'(0));
    check("rst_valid",  192'(result_valid), 192'(0));
    check("rst_busy",   192'(busy), 192'(0));
    check("rst_class",  192'(result_class), 192'(0));
    check("rst_score",  192'(result_score), 192'(0));
    check("rst_logits", 192'(result_logits), 192'(0));
    check("rst_errs",   192'({err_timeout, err_overrun}), 192'(0));

    // First run: bias load, then pixel_store_done 12 cycles later
    weight_loaded = 1'b1;
    layer6_done = 1'b1;
    tick();
    layer6_done = 1'b0;
    check("r1_bias", 192'(bias_store_done), 192'(1));
    check("r1_busy", 192'(busy), 192'(1));
    tick();
    check("r1_bias_pulse", 192'(bias_store_done), 192'(0));
    repeat (10) tick();
    check("r1_pixel_early", 192'(pixel_store_done), 192'(0));
    tick();
    check("r1_pixel", 192'(pixel_store_done), 192'(1));
    tick();
    fc_output_data = pack10(v1);
    fc_calculation_done = 1'b1;
    tick();
    fc_calculation_done = 1'b0;
    fc_output_data = '0;
    check("r1_logits", 192'(result_logits), 192'(pack10(v1)));
    repeat (8) tick();
    check("r1_valid_early", 192'(result_valid), 192'(0));
    tick();
    check("r1_valid", 192'(result_valid), 192'(1));
    check("r1_class", 192'(result_class), 192'(2));
    check("r1_score", 192'(result_score), 192'(16'd9));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("r1_accept", 192'({result_valid, busy}), 192'(0));

    // Second run: bias already programmed, ready held high in advance
    result_ready = 1'b1;
    layer6_done = 1'b1;
    tick();
    layer6_done = 1'b0;
    check("r2_pixel", 192'(pixel_store_done), 192'(1));
    check("r2_no_bias", 192'(bias_store_done), 192'(0));
    tick();
    fc_output_data = pack10(v2);
    fc_calculation_done = 1'b1;
    tick();
    fc_calculation_done = 1'b0;
    repeat (9) tick();
    check("r2_valid", 192'(result_valid), 192'(1));
    check("r2_class", 192'(result_class), 192'(0));
    check("r2_score", 192'(result_score), 192'(16'h8000));
    tick();
    check("r2_accept", 192'(result_valid), 192'(0));
    result_ready = 1'b0;

    // Backpressure with pending trigger and overrun
    layer6_done = 1'b1;
    tick();
    layer6_done = 1'b0;
    tick();
    fc_output_data = pack10(v3);
    fc_calculation_done = 1'b1;
    tick();
    fc_calculation_done = 1'b0;
    fc_output_data = '0;
    repeat (9) tick();
    check("bp_valid", 192'(result_valid), 192'(1));
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3 || i == 8) layer6_done = 1'b1;
      tick();
      layer6_done = 1'b0;
      if (result_valid !== 1'b1 || result_class !== 4'd7 || result_score !== 16'd100) flag = 1'b0;
      if (i == 3) check("bp_no_overrun", 192'(err_overrun), 192'(0));
      if (i == 8) check("bp_overrun", 192'(err_overrun), 192'(1));
    end
    check("bp_stable", 192'(flag), 192'(1));
    check("bp_class", 192'(result_class), 192'(7));
    check("bp_score", 192'(result_score), 192'(16'd100));
    check("bp_logits", 192'(result_logits), 192'(pack10(v3)));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("bp_accept", 192'({result_valid, pixel_store_done}), 192'(0));
    tick();
    check("bp_pending_start", 192'(pixel_store_done), 192'(1));

    // Watchdog: no done for the pending run
    flag = 1'b0;
    repeat (1024) begin
      tick();
      if (result_valid !== 1'b0) flag = 1'b1;
    end
    check("wd_not_yet", 192'(err_timeout), 192'(0));
    check("wd_busy", 192'(busy), 192'(1));
    tick();
    if (result_valid !== 1'b0) flag = 1'b1;
    check("wd_timeout", 192'(err_timeout), 192'(1));
    check("wd_idle", 192'(busy), 192'(0));
    check("wd_no_valid", 192'(flag), 192'(0));
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("wd_clear", 192'({err_timeout, err_overrun}), 192'(0));

    // Reset in the middle of ARGMAX
    layer6_done = 1'b1;
    tick();
    layer6_done = 1'b0;
    check("mr_pixel", 192'(pixel_store_done), 192'(1));
    tick();
    fc_output_data = pack10(v1);
    fc_calculation_done = 1'b1;
    tick();
    fc_calculation_done = 1'b0;
    fc_output_data = '0;
    tick();
    tick();
    check("mr_in_argmax", 192'({busy, result_valid}), 192'(2'b10));
    #1 rst = 1'b1;
    #1;
    check("mr_strobes", 192'({bias_store_done, pixel_store_done, result_valid, busy}), 192'(0));
    check("mr_result", 192'({result_class, result_score}), 192'(0));
    check("mr_logits", 192'(result_logits), 192'(0));
    tick();
    rst = 1'b0;
    tick();

    // Weights not ready: trigger held pending, bias reload on weight_loaded
    weight_loaded = 1'b0;
    layer6_done = 1'b1;
    tick();
    layer6_done = 1'b0;
    flag = 1'b0;
    repeat (5) begin
      if (bias_store_done || pixel_store_done || busy) flag = 1'b1;
      tick();
    end
    check("wl_no_start", 192'(flag), 192'(0));
    weight_loaded = 1'b1;
    tick();
    check("wl_bias", 192'(bias_store_done), 192'(1));
    repeat (11) tick();
    check("wl_pixel_early", 192'(pixel_store_done), 192'(0));
    tick();
    check("wl_pixel", 192'(pixel_store_done), 192'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
